// File: rtl/dct4_transpose_buf.sv
// Ping-pong 4x4 transpose buffer between the row and column stages of a 4-point 2-D DCT.
// Rows are written into one bank while columns of the other bank are read out.
module dct4_transpose_buf #(
  parameter int WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_d0,
  input  logic signed [WIDTH-1:0] in_d1,
  input  logic signed [WIDTH-1:0] in_d2,
  input  logic signed [WIDTH-1:0] in_d3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_c0,
  output logic signed [WIDTH-1:0] out_c1,
  output logic signed [WIDTH-1:0] out_c2,
  output logic signed [WIDTH-1:0] out_c3,
  output logic [1:0]              out_idx,
  output logic                    out_last
);

  logic signed [WIDTH-1:0] r_bank [2][4][4];
  logic [1:0]              r_full;
  logic                    r_wr_bank;
  logic                    r_rd_bank;
  logic [1:0]              r_wr_cnt;
  logic [1:0]              r_rd_cnt;

  logic w_in_fire;
  logic w_out_fire;
  logic w_wr_done;
  logic w_rd_done;

  // Both handshake qualifiers come straight from flops, so out_ready never reaches in_ready.
  assign in_ready   = !r_full[r_wr_bank];
  assign out_valid  = r_full[r_rd_bank];
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_wr_done  = w_in_fire && (r_wr_cnt == 2'd3);
  assign w_rd_done  = w_out_fire && (r_rd_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_cnt  <= 2'd0;
      r_rd_cnt  <= 2'd0;
    end else begin
      if (w_in_fire) begin
        r_wr_cnt <= r_wr_cnt + 2'd1;
      end
      if (w_wr_done) begin
        r_full[r_wr_bank] <= 1'b1;
        r_wr_bank         <= !r_wr_bank;
      end
      if (w_out_fire) begin
        r_rd_cnt <= r_rd_cnt + 2'd1;
      end
      // The write bank is never full, so a simultaneous set and clear hit different banks.
      if (w_rd_done) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= !r_rd_bank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            r_bank[b][r][c] <= '0;
          end
        end
      end
    end else if (w_in_fire) begin
      r_bank[r_wr_bank][r_wr_cnt][0] <= in_d0;
      r_bank[r_wr_bank][r_wr_cnt][1] <= in_d1;
      r_bank[r_wr_bank][r_wr_cnt][2] <= in_d2;
      r_bank[r_wr_bank][r_wr_cnt][3] <= in_d3;
    end
  end

  assign out_c0   = r_bank[r_rd_bank][0][r_rd_cnt];
  assign out_c1   = r_bank[r_rd_bank][1][r_rd_cnt];
  assign out_c2   = r_bank[r_rd_bank][2][r_rd_cnt];
  assign out_c3   = r_bank[r_rd_bank][3][r_rd_cnt];
  assign out_idx  = r_rd_cnt;
  assign out_last = (r_rd_cnt == 2'd3);

endmodule

// File: tb/tb_dct4_transpose_buf.sv
// Bench for dct4_transpose_buf: directed table of blocks, handshake corner sequences,
// and random traffic checked against a row-queue / column-queue transpose model.
module tb_dct4_transpose_buf;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [10:0] in_d0 = '0, in_d1 = '0, in_d2 = '0, in_d3 = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [10:0] out_c0, out_c1, out_c2, out_c3;
  logic [1:0]         out_idx;
  logic               out_last;

  dct4_transpose_buf #(.WIDTH(11)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_d0(in_d0), .in_d1(in_d1), .in_d2(in_d2), .in_d3(in_d3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c0(out_c0), .out_c1(out_c1), .out_c2(out_c2), .out_c3(out_c3),
    .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stalls   = 0;
  int hs_n     = 0;
  int hs_first = -1;
  int hs_last  = -1;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0][10:0] d;
    logic [1:0]       idx;
    logic             last;
  } col_t;

  logic [3:0][10:0] rows_q[$];
  col_t             colq[$];
  int               held = 0;
  int               cols_done = 0;
  logic             have_snap = 1'b0;
  logic [43:0]      snap_d;
  logic [1:0]       snap_idx;
  logic             snap_last;

  function automatic logic [43:0] dut_col();
    return {out_c3, out_c2, out_c1, out_c0};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      rows_q.delete();
      colq.delete();
      held = 0;
      cols_done = 0;
      have_snap = 1'b0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(held < 2));
      chk("out_valid", 64'(out_valid), 64'(held > 0));
      if (have_snap) begin
        chk("stall_valid", 64'(out_valid), 64'(1'b1));
        chk("stall_data", 64'(dut_col()), 64'(snap_d));
        chk("stall_idx", 64'(out_idx), 64'(snap_idx));
        chk("stall_last", 64'(out_last), 64'(snap_last));
      end
      if (out_valid && out_ready) begin
        if (colq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL col_extra: got column %0h with none expected", dut_col());
        end else begin
          col_t e;
          e = colq.pop_front();
          chk("col_data", 64'(dut_col()), 64'(e.d));
          chk("col_idx", 64'(out_idx), 64'(e.idx));
          chk("col_last", 64'(out_last), 64'(e.last));
          cols_done++;
          if (cols_done == 4) begin
            cols_done = 0;
            held--;
          end
        end
        hs_n++;
        if (hs_first < 0) hs_first = cyc;
        hs_last = cyc;
      end
      have_snap = out_valid && !out_ready;
      snap_d    = dut_col();
      snap_idx  = out_idx;
      snap_last = out_last;
      if (in_valid && in_ready) begin
        rows_q.push_back({in_d3, in_d2, in_d1, in_d0});
        if (rows_q.size() == 4) begin
          for (int j = 0; j < 4; j++) begin
            col_t c;
            for (int k = 0; k < 4; k++) c.d[k] = rows_q[k][j];
            c.idx  = 2'(j);
            c.last = (j == 3);
            colq.push_back(c);
          end
          rows_q.delete();
          held++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_row(input logic [10:0] a, input logic [10:0] b,
                          input logic [10:0] c, input logic [10:0] d);
    int n = 0;
    in_d0 = a; in_d1 = b; in_d2 = c; in_d3 = d;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL row_timeout: in_ready still 0 after %0d cycles, required 1", n);
    end else begin
      @(posedge clk); #1;
    end
    stalls += n;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((colq.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d columns still pending, required 0", colq.size());
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({nm, "_data"}, 64'(dut_col()), 64'(0));
    chk({nm, "_idx"}, 64'(out_idx), 64'(0));
    chk({nm, "_last"}, 64'(out_last), 64'(0));
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic [15:0][10:0] r;
    logic [15:0][10:0] c;
  } vec_t;

  vec_t tbl[2];

  initial begin
    int r0[16] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    int c0[16] = '{1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15, 4, 8, 12, 16};
    int r1[16] = '{-1024, 1023, -1, 0, 1023, -1024, 0, -1,
                   -1024, -1024, 1023, 1023, 0, 1, -2, -1024};
    int c1[16] = '{-1024, 1023, -1024, 0, 1023, -1024, -1024, 1,
                   -1, 0, 1023, -2, 0, -1, 1023, -1024};
    for (int i = 0; i < 16; i++) begin
      tbl[0].r[i] = 11'(r0[i]);
      tbl[0].c[i] = 11'(c0[i]);
      tbl[1].r[i] = 11'(r1[i]);
      tbl[1].c[i] = 11'(c1[i]);
    end

    // reset state
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_in_ready", 64'(in_ready), 64'(1));

    // single blocks: columns on consecutive cycles, one cycle after the 4th row
    out_ready = 1'b1;
    for (int v = 0; v < 2; v++) begin
      for (int r = 0; r < 4; r++)
        send_row(tbl[v].r[r*4+0], tbl[v].r[r*4+1], tbl[v].r[r*4+2], tbl[v].r[r*4+3]);
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        chk("tbl_valid", 64'(out_valid), 64'(1));
        chk("tbl_col", 64'(dut_col()),
            64'({tbl[v].c[j*4+3], tbl[v].c[j*4+2], tbl[v].c[j*4+1], tbl[v].c[j*4+0]}));
        chk("tbl_idx", 64'(out_idx), 64'(j));
        chk("tbl_last", 64'(out_last), 64'(j == 3));
        @(posedge clk); #1;
      end
      @(negedge clk);
      chk("tbl_done_valid", 64'(out_valid), 64'(0));
      @(posedge clk); #1;
    end

    // back-to-back blocks: no input stalls, 8 contiguous columns
    stalls = 0; hs_n = 0; hs_first = -1;
    for (int r = 0; r < 8; r++)
      send_row(11'(200 + 4*r), 11'(201 + 4*r), 11'(202 + 4*r), 11'(203 + 4*r));
    wait_drain();
    chk("b2b_stalls", 64'(stalls), 64'(0));
    chk("b2b_cols", 64'(hs_n), 64'(8));
    chk("b2b_contig", 64'(hs_last - hs_first), 64'(7));

    // backpressure: two full banks block the 9th row until a bank frees
    out_ready = 1'b0;
    for (int r = 0; r < 8; r++)
      send_row(11'(-300 - r), 11'(310 + r), 11'(-320 - r), 11'(330 + r));
    chk("bp_full_in_ready", 64'(in_ready), 64'(0));
    in_d0 = 11'(500); in_d1 = 11'(501); in_d2 = 11'(502); in_d3 = 11'(503);
    in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_hold_in_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    begin
      int n = 0;
      while (!in_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("bp_release_cycles", 64'(n), 64'(4));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int r = 0; r < 3; r++)
      send_row(11'(510 + r), 11'(520 + r), 11'(530 + r), 11'(540 + r));
    wait_drain();

    // stall stability with out_ready toggling, then fully random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_d0 = 11'($urandom); in_d1 = 11'($urandom);
      in_d2 = 11'($urandom); in_d3 = 11'($urandom);
      out_ready = (i < 200) ? ~out_ready : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // reset mid-block: partial data discarded, only the new block appears
    apply_reset();
    send_row(11'(77), 11'(-78), 11'(79), 11'(-80));
    send_row(11'(81), 11'(-82), 11'(83), 11'(-84));
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    hs_n = 0;
    for (int r = 0; r < 4; r++)
      send_row(11'(-600 - r), 11'(610 + r), 11'(-620 - r), 11'(630 + r));
    wait_drain();
    repeat (4) begin @(posedge clk); #1; end
    chk("midrst_cols", 64'(hs_n), 64'(4));
    chk("final_pending", 64'(colq.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
